// File: rtl/memlog_pkg.sv
// Shared definitions for the multi-channel MEMLog capture block:
// FSM state encoding, capture-mode constants and the readout latency.
package memlog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PRE,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_TRIG    = 1'b1;

  // Address register followed by the RAM output register.
  localparam int RD_LAT = 2;

endpackage

// File: rtl/memlog_bram.sv
// Simple dual-port sample memory: synchronous write, registered synchronous read.
// The output register holds its value unless a read is enabled.
module memlog_bram #(
  parameter int NB_WORD = 32,
  parameter int NB_ADDR = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [NB_ADDR-1:0] wr_addr,
  input  logic [NB_WORD-1:0] wr_data,
  input  logic               re,
  input  logic [NB_ADDR-1:0] rd_addr,
  output logic [NB_WORD-1:0] rd_data
);

  logic [NB_WORD-1:0] mem [2**NB_ADDR];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Only the output register is reset; the array contents survive reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/memlog_trig.sv
// Multi-channel decimating capture into block RAM with one-shot fill and
// circular pre/post-trigger modes; readback is by logical address (0 = oldest).
module memlog_trig
  import memlog_pkg::*;
#(
  parameter int NB_DATA = 16,
  parameter int NB_CH   = 2,
  parameter int NB_ADDR = 15,
  parameter int NB_DEC  = 8
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic [NB_CH*NB_DATA-1:0] i_data,
  input  logic                     i_valid,
  input  logic                     i_run_log,
  input  logic                     i_mode,
  input  logic                     i_trig,
  input  logic [NB_ADDR-1:0]       i_post_cnt,
  input  logic [NB_DEC-1:0]        i_decim,
  input  logic                     i_read_log,
  input  logic [NB_ADDR-1:0]       i_addr,
  output logic [NB_CH*NB_DATA-1:0] o_data,
  output logic                     o_rd_valid,
  output logic                     o_busy,
  output logic                     o_mem_full
);

  localparam int NB_WORD = NB_CH * NB_DATA;
  localparam int DEPTH   = 2**NB_ADDR;

  state_t state, state_n;

  logic               run_q;
  logic [NB_ADDR-1:0] post_r;
  logic [NB_DEC-1:0]  decim_r;
  logic [NB_DEC-1:0]  dec_cnt;
  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR-1:0] start_ptr, start_n;
  logic [NB_ADDR-1:0] post_left, post_n;
  logic [NB_ADDR:0]   pre_cnt;
  logic [NB_ADDR:0]   pre_cnt_inc;
  logic [NB_ADDR:0]   pre_thresh;
  logic [NB_ADDR-1:0] rd_addr;
  logic               rd_pend;

  logic run_edge;
  logic capturing;
  logic arm;
  logic we;

  assign run_edge  = i_run_log & ~run_q;
  assign capturing = (state == ST_FILL) || (state == ST_PRE) ||
                     (state == ST_ARMED) || (state == ST_POST);
  assign arm       = run_edge && ((state == ST_IDLE) || (state == ST_DONE));
  assign we        = capturing && i_run_log && i_valid && (dec_cnt == '0);

  // i_post_cnt is NB_ADDR bits wide, so it can never exceed DEPTH-1 and the
  // clamp is inherent; the pre-fill length is therefore always at least 1.
  assign pre_cnt_inc = pre_cnt + (NB_ADDR+1)'(1);
  assign pre_thresh  = (NB_ADDR+1)'(DEPTH) - {1'b0, post_r};

  assign o_busy     = capturing;
  assign o_mem_full = (state == ST_DONE);

  always_comb begin
    state_n = state;
    start_n = start_ptr;
    post_n  = post_left;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (run_edge) begin
          state_n = (i_mode == MODE_TRIG) ? ST_PRE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (we && (wr_ptr == '1)) begin
          state_n = ST_DONE;
          start_n = '0;
        end
      end
      ST_PRE: begin
        if (we && (pre_cnt_inc == pre_thresh)) begin
          state_n = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (i_trig) begin
          if (post_r == '0) begin
            state_n = ST_DONE;
            start_n = wr_ptr + NB_ADDR'(we);
          end else begin
            state_n = ST_POST;
            post_n  = post_r;
          end
        end
      end
      ST_POST: begin
        if (we) begin
          if (post_left == NB_ADDR'(1)) begin
            state_n = ST_DONE;
            start_n = wr_ptr + NB_ADDR'(1);
          end else begin
            post_n = post_left - NB_ADDR'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // Dropping i_run_log abandons a capture from any busy state.
    if (capturing && !i_run_log) begin
      state_n = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      run_q     <= 1'b0;
      post_r    <= '0;
      decim_r   <= '0;
      dec_cnt   <= '0;
      wr_ptr    <= '0;
      start_ptr <= '0;
      post_left <= '0;
      pre_cnt   <= '0;
    end else begin
      state     <= state_n;
      run_q     <= i_run_log;
      start_ptr <= start_n;
      post_left <= post_n;
      if (arm) begin
        post_r  <= i_post_cnt;
        decim_r <= i_decim;
        dec_cnt <= '0;
        wr_ptr  <= '0;
        pre_cnt <= '0;
      end else if (capturing && i_run_log && i_valid) begin
        dec_cnt <= (dec_cnt == decim_r) ? '0 : dec_cnt + NB_DEC'(1);
        if (we) begin
          wr_ptr <= wr_ptr + NB_ADDR'(1);
          if (state == ST_PRE) begin
            pre_cnt <= pre_cnt_inc;
          end
        end
      end
    end
  end

  // Logical-to-physical translation happens in the address stage; the sum
  // wraps modulo DEPTH by truncation.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      rd_addr    <= '0;
      rd_pend    <= 1'b0;
      o_rd_valid <= 1'b0;
    end else begin
      rd_pend    <= (state == ST_DONE) && i_read_log;
      o_rd_valid <= rd_pend;
      if ((state == ST_DONE) && i_read_log) begin
        rd_addr <= start_ptr + i_addr;
      end
    end
  end

  memlog_bram #(
    .NB_WORD (NB_WORD),
    .NB_ADDR (NB_ADDR)
  ) u_bram (
    .clk     (clk),
    .rst     (i_rst),
    .we      (we),
    .wr_addr (wr_ptr),
    .wr_data (i_data),
    .re      (rd_pend),
    .rd_addr (rd_addr),
    .rd_data (o_data)
  );

endmodule
